// File: rtl/ctrl_monitor.sv
// Retirement monitor for the RV32I core: checks decoded controls against the per-opcode table,
// keeps saturating class counters, queues violations in a small FIFO and reports run status.
module ctrl_monitor #(
    parameter int unsigned INST_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned ERR_DEPTH   = 4,
    parameter int unsigned HALT_ON_ERR = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  valid_i,
    input  logic [INST_WIDTH-1:0] pc_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic                  branch_i,
    input  logic                  take_i,
    input  logic                  mem_write_i,
    input  logic                  alu_src_a_i,
    input  logic                  alu_src_b_i,
    input  logic [1:0]            result_mux_i,
    input  logic [3:0]            cnt_sel_i,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic [1:0]            state_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic                  err_valid_o,
    output logic [INST_WIDTH-1:0] err_pc_o,
    output logic [7:0]            err_code_o,
    input  logic                  err_ready_i,
    output logic                  err_overflow_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StRun  = 2'b01;
    localparam logic [1:0] StDone = 2'b10;
    localparam logic [1:0] StFail = 2'b11;

    localparam int unsigned PW = $clog2(ERR_DEPTH);

    logic [6:0]  opcode;
    logic [6:0]  ctl, exp_ctl, diff;
    logic        chk;
    logic [3:0]  cls;
    logic [7:0]  err_code;
    logic        retire, viol;
    logic [15:0] inc;
    logic [1:0]  state_q, state_d;
    logic        unused_inst;

    logic [CNT_WIDTH-1:0] cnt_q [16];
    logic [CNT_WIDTH-1:0] cnt_o_q;

    logic [PW:0]           wptr_q, rptr_q;
    logic                  empty, full, push, pop, drop, ovf_q;
    logic [INST_WIDTH-1:0] mem_pc_q   [ERR_DEPTH];
    logic [7:0]            mem_code_q [ERR_DEPTH];

    assign opcode      = inst_i[6:0];
    assign unused_inst = ^inst_i[INST_WIDTH-1:7];
    assign ctl         = {branch_i, take_i, mem_write_i, result_mux_i, alu_src_a_i, alu_src_b_i};
    assign diff        = ctl ^ exp_ctl;

    always_comb begin
        exp_ctl  = '0;
        chk      = 1'b1;
        cls      = 4'd11;
        err_code = '0;
        case (opcode)
            OP_LUI:    begin cls = 4'd0; exp_ctl = 7'b000_00_01; end
            OP_AUIPC:  begin cls = 4'd1; exp_ctl = 7'b000_00_11; end
            OP_JAL:    begin cls = 4'd2; exp_ctl = 7'b110_01_11; end
            OP_JALR:   begin cls = 4'd3; exp_ctl = 7'b110_01_01; end
            // branch is free; take is only legal when branch is also set
            OP_BRANCH: begin
                cls     = 4'd4;
                exp_ctl = {branch_i, take_i & branch_i, 5'b0_00_11};
            end
            OP_LOAD:   begin cls = 4'd5; exp_ctl = 7'b000_10_01; end
            OP_STORE:  begin cls = 4'd6; exp_ctl = 7'b001_00_01; end
            OP_ALUI:   begin cls = 4'd7; exp_ctl = 7'b000_00_01; end
            OP_ALU:    begin cls = 4'd8; exp_ctl = 7'b000_00_00; end
            OP_FENCE:  begin cls = 4'd9; chk = 1'b0; err_code = 8'h40; end
            OP_SYSTEM: begin cls = 4'd10; chk = 1'b0; end
            default:   begin cls = 4'd11; chk = 1'b0; err_code = 8'h80; end
        endcase
        if (chk) begin
            err_code = {2'b00, diff[0], diff[1], |diff[3:2], diff[4], diff[5], diff[6]};
        end
    end

    assign retire = valid_i && (state_q == StRun);
    assign viol   = retire && (err_code != 8'h00);

    always_comb begin
        inc = '0;
        if (retire) begin
            inc[cls] = 1'b1;
            inc[12]  = 1'b1;
            inc[13]  = viol;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
            cnt_o_q <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (inc[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
            // entries 14 and 15 never increment, so those selects read 0
            cnt_o_q <= cnt_q[cnt_sel_i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (en_i) state_d = StRun;
            StRun: begin
                if (retire && (opcode == OP_SYSTEM)) state_d = StDone;
                else if (viol && (HALT_ON_ERR != 0)) state_d = StFail;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW-1:0] == rptr_q[PW-1:0]) && (wptr_q[PW] != rptr_q[PW]);
    assign pop   = err_ready_i && !empty;
    // a pop frees the head slot in the same cycle, so a full FIFO still accepts
    assign push  = viol && (!full || pop);
    assign drop  = viol && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (drop) ovf_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wptr_q[PW-1:0]]   <= pc_i;
            mem_code_q[wptr_q[PW-1:0]] <= err_code;
        end
    end

    assign err_valid_o    = !empty;
    assign err_pc_o       = empty ? '0 : mem_pc_q[rptr_q[PW-1:0]];
    assign err_code_o     = empty ? '0 : mem_code_q[rptr_q[PW-1:0]];
    assign err_overflow_o = ovf_q;
    assign cnt_o          = cnt_o_q;
    assign state_o        = state_q;
    assign done_o         = (state_q == StDone);
    assign fail_o         = (state_q == StFail);

endmodule
